// File: rtl/sram_mem_controller.sv
// MEM-stage controller for a 16-bit asynchronous SRAM: each 32-bit word takes two
// half-accesses, low half first, and ready stays low for the whole transfer.
module sram_mem_controller #(
  parameter int BASE_ADDR     = 1024,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  tri   [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);

  // Handshake: a request (rd_en|wr_en) is accepted in IDLE; ready drops in that
  // same cycle and rises only in DONE, where the pipeline advances on the next edge.
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_write_q;
  logic [16:0]     word_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic [17:0]     addr_q;

  logic            req;
  logic            last;
  logic            access;
  logic [16:0]     req_word;

  assign req      = rd_en | wr_en;
  assign last     = (cnt_q == LAST_CNT);
  assign access   = (state_q == LOW) || (state_q == HIGH);
  // Out-of-range addresses simply wrap within the 17-bit word space.
  assign req_word = 17'((address - 32'(BASE_ADDR)) >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_d = LOW;
          cnt_d   = '0;
        end
      end
      LOW: begin
        if (last) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        op_write_q <= wr_en;
        word_q     <= req_word;
        wdata_q    <= write_data;
        addr_q     <= {req_word, 1'b0};
      end
      if (state_q == LOW && last) begin
        addr_q <= {word_q, 1'b1};
        if (!op_write_q) rdata_q[15:0] <= SRAM_DQ;
      end
      if (state_q == HIGH && last && !op_write_q) rdata_q[31:16] <= SRAM_DQ;
    end
  end

  assign read_data = rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = ~(access & op_write_q);
  assign SRAM_OE_N = ~(access & ~op_write_q);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = (access && op_write_q)
                     ? ((state_q == LOW) ? wdata_q[15:0] : wdata_q[31:16])
                     : 16'hzzzz;
  assign dbg_state = state_q;

endmodule
